// File: rtl/axis_pkt_builder.sv
// AXI-Stream packet builder: emits a length header beat followed by the
// payload beats, generating tlast/tkeep from the descriptor length.
module axis_pkt_builder #(
  parameter int TDATA_WIDTH    = 64,
  parameter int MAX_PKT_LENGTH = 16
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic [MAX_PKT_LENGTH-1:0]   desc_len,
  input  logic                        desc_valid,
  output logic                        desc_ready,
  input  logic [TDATA_WIDTH-1:0]      s_tdata,
  input  logic                        s_tlast,
  input  logic                        s_tvalid,
  output logic                        s_tready,
  output logic [TDATA_WIDTH-1:0]      m_tdata,
  output logic [TDATA_WIDTH/8-1:0]    m_tkeep,
  output logic                        m_tlast,
  output logic                        m_tvalid,
  input  logic                        m_tready,
  output logic                        pkt_done,
  output logic                        len_err
);

  localparam int BYTES = TDATA_WIDTH / 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    HDR       = 2'd1,
    PAY       = 2'd2,
    WAIT_LAST = 2'd3
  } state_t;

  state_t                     state, state_nx;
  logic                       armed;
  logic [MAX_PKT_LENGTH-1:0]  len_q;
  logic [MAX_PKT_LENGTH-1:0]  beats_q;
  logic [BYTES-1:0]           keep_q;
  logic                       load_ok;
  logic                       desc_acc;
  logic                       hdr_ld;
  logic                       pay_ld;
  logic                       bubble;
  logic                       done;

  // Number of payload beats: ceil(len/BYTES), computed wide so len+BYTES-1 cannot wrap.
  function automatic logic [MAX_PKT_LENGTH-1:0] calc_beats(input logic [MAX_PKT_LENGTH-1:0] len);
    int sum;
    sum = int'(len) + BYTES - 1;
    return MAX_PKT_LENGTH'(sum / BYTES);
  endfunction

  // Byte enables of the final payload beat; a length that fills the beat keeps all bytes.
  function automatic logic [BYTES-1:0] calc_keep(input logic [MAX_PKT_LENGTH-1:0] len);
    int               rem;
    logic [BYTES-1:0] k;
    rem = int'(len) % BYTES;
    for (int i = 0; i < BYTES; i++) begin
      k[i] = (rem == 0) || (i < rem);
    end
    return k;
  endfunction

  // Header beat: length in the low bits, everything above is zero.
  function automatic logic [TDATA_WIDTH-1:0] build_hdr(input logic [MAX_PKT_LENGTH-1:0] len);
    logic [TDATA_WIDTH-1:0] h;
    h = '0;
    h[MAX_PKT_LENGTH-1:0] = len;
    return h;
  endfunction

  // The output stage can take a new beat when empty or being drained this cycle.
  assign load_ok = !m_tvalid || m_tready;

  // State register; armed keeps desc_ready low in the first cycle out of reset.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state <= IDLE;
      armed <= 1'b0;
    end else begin
      state <= state_nx;
      armed <= 1'b1;
    end
  end

  // Next-state logic and per-cycle strobes for the datapath.
  always_comb begin
    state_nx   = state;
    desc_ready = 1'b0;
    s_tready   = 1'b0;
    desc_acc   = 1'b0;
    hdr_ld     = 1'b0;
    pay_ld     = 1'b0;
    bubble     = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        desc_ready = armed;
        if (armed && desc_valid) begin
          desc_acc = 1'b1;
          state_nx = HDR;
        end
      end
      HDR: begin
        if (load_ok) begin
          hdr_ld   = 1'b1;
          state_nx = (beats_q != '0) ? PAY : WAIT_LAST;
        end
      end
      PAY: begin
        s_tready = load_ok;
        if (load_ok) begin
          if (s_tvalid) begin
            pay_ld = 1'b1;
            if (beats_q == MAX_PKT_LENGTH'(1)) state_nx = WAIT_LAST;
          end else begin
            bubble = 1'b1;
          end
        end
      end
      WAIT_LAST: begin
        if (m_tvalid && m_tready && m_tlast) begin
          done     = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Descriptor capture and remaining-beat counter.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      len_q   <= '0;
      beats_q <= '0;
      keep_q  <= '0;
    end else if (desc_acc) begin
      len_q   <= desc_len;
      beats_q <= calc_beats(desc_len);
      keep_q  <= calc_keep(desc_len);
    end else if (pay_ld) begin
      beats_q <= beats_q - MAX_PKT_LENGTH'(1);
    end
  end

  // Output register stage plus completion and length-check pulses.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      m_tdata  <= '0;
      m_tkeep  <= '0;
      m_tlast  <= 1'b0;
      m_tvalid <= 1'b0;
      pkt_done <= 1'b0;
      len_err  <= 1'b0;
    end else begin
      pkt_done <= done;
      len_err  <= pay_ld && (s_tlast != (beats_q == MAX_PKT_LENGTH'(1)));
      if (hdr_ld) begin
        m_tdata  <= build_hdr(len_q);
        m_tkeep  <= '1;
        m_tlast  <= (len_q == '0);
        m_tvalid <= 1'b1;
      end else if (pay_ld) begin
        m_tdata  <= s_tdata;
        m_tvalid <= 1'b1;
        if (beats_q == MAX_PKT_LENGTH'(1)) begin
          m_tlast <= 1'b1;
          m_tkeep <= keep_q;
        end else begin
          m_tlast <= 1'b0;
          m_tkeep <= '1;
        end
      end else if (bubble || done) begin
        m_tvalid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/axis_pkt_builder.md
Name: axis_pkt_builder

Overview:
- Transmit-side counterpart of the parser's length extraction.
- Takes a per-packet length descriptor and a raw payload stream, and emits an AXI-Stream packet.
- Beat 1 is a header carrying the packet length. It is followed by ceil(len/BYTES) payload beats, with tlast and tkeep generated from the length.
- Used to build stimulus for the parser pipeline and as the egress framer.

Parameters:
- TDATA_WIDTH, 64, stream data width in bits; must be a multiple of 8. BYTES = TDATA_WIDTH/8.
- MAX_PKT_LENGTH, 16, width in bits of the length field, in bytes. Maximum length is 2^MAX_PKT_LENGTH-1.

Ports:
- aclk  in  1  clock
- aresetn  in  1  synchronous active-low reset
- desc_len  in  MAX_PKT_LENGTH  payload length in bytes
- desc_valid  in  1  descriptor valid
- desc_ready  out  1  descriptor accepted when valid&ready
- s_tdata  in  TDATA_WIDTH  payload data
- s_tlast  in  1  source end-of-payload marker; checked only, never used for framing
- s_tvalid  in  1  payload valid
- s_tready  out  1  payload ready
- m_tdata  out  TDATA_WIDTH  output data
- m_tkeep  out  BYTES  byte enables
- m_tlast  out  1  last beat of packet
- m_tvalid  out  1  output valid
- m_tready  in  1  downstream ready
- pkt_done  out  1  one-cycle pulse when the tlast beat is accepted downstream
- len_err  out  1  one-cycle pulse on s_tlast/length mismatch

Behaviour:
- All state is updated on the rising edge of aclk.
- Reset (aresetn=0 at a clock edge):
  - State goes to IDLE.
  - m_tvalid, m_tlast, pkt_done, len_err, s_tready and desc_ready go to 0.
  - m_tdata and m_tkeep go to 0. Beat counter goes to 0.
  - Reset mid-packet abandons the packet. There is no partial flush, and the first beat after reset is always a header.
- The output is a single registered stage. It loads when load_ok = !m_tvalid || m_tready. m_* are held stable while m_tvalid && !m_tready.
- Header beat format:
  - m_tdata[MAX_PKT_LENGTH-1:0] = len.
  - All upper bits are 0.
  - m_tkeep is all-ones.
- FSM states:
  - IDLE:
    - desc_ready=1. On desc_valid, latch len and go to HDR.
    - Latch beats = ceil(len/BYTES); width MAX_PKT_LENGTH, no overflow.
    - Latch last_keep = (len%BYTES==0) ? all-ones : (1<<(len%BYTES))-1.
  - HDR:
    - desc_ready=0 and s_tready=0.
    - When load_ok, load the header into the output register with m_tvalid=1 and m_tlast=(len==0).
    - Next state is PAY if beats>0, otherwise WAIT_LAST.
  - PAY:
    - s_tready = load_ok.
    - On s_tvalid&&s_tready, load s_tdata and decrement beats.
    - When beats==1 on that transfer: m_tlast=1, m_tkeep=last_keep, next state WAIT_LAST.
    - Otherwise m_tkeep is all-ones and m_tlast=0.
    - If load_ok && !s_tvalid, clear m_tvalid (bubble).
  - WAIT_LAST:
    - s_tready=0.
    - When the tlast beat is accepted (m_tvalid&&m_tready&&m_tlast): pulse pkt_done, clear m_tvalid, go to IDLE.
    - The next descriptor can be accepted in the cycle after pkt_done.
- Throughput:
  - One beat per clock in PAY with continuous valid/ready.
  - Header insertion costs 1 cycle.
  - Inter-packet overhead is 2 idle cycles (IDLE, then HDR load).
- Latency: desc accept to header m_tvalid is 1 cycle.
- Length checking:
  - The length is authoritative.
  - len_err pulses in the cycle after a payload transfer where s_tlast != (beats==1). This covers both an early tlast and a missing tlast.
  - Framing is unaffected by len_err; excess source beats remain for the next packet.
- Sequencing: a new descriptor is not accepted while a packet is in flight (desc_ready=0 outside IDLE).

Test Plan:
1. TDATA_WIDTH=64, desc_len=20, 3 payload beats with s_tlast on the 3rd, m_tready=1.
   - Header beat: m_tdata=0x14, tkeep=0xFF.
   - Then 3 payload beats, the last with tkeep=0x0F and tlast=1.
   - pkt_done pulses once; len_err stays 0.
2. desc_len=16.
   - 2 payload beats, both tkeep=0xFF, tlast on the 2nd.
   - desc_len=8: exactly 1 payload beat with tlast.
3. desc_len=0.
   - Single header beat with m_tdata=0, tlast=1, tkeep=0xFF.
   - s_tready never asserts.
   - pkt_done pulses.
4. desc_len=24, m_tready toggling 1010… and s_tvalid gapped.
   - Output data, order and tlast are identical to the no-stall case.
   - m_* are stable during every stall; no beat is dropped or duplicated.
5. desc_len=24 with s_tlast on beat 2.
   - len_err pulses once.
   - The packet still emits 3 payload beats with tlast on the 3rd.
6. aresetn=0 for 1 cycle mid-payload of a len=40 packet.
   - All outputs are 0 the cycle after reset.
   - Next desc_len=8 produces header + 1 beat with correct framing.
